sr_config_sequencer: RTL and testbench

- Sequences the chip's serial configuration shift register from the command FIFO (fifo1) and captures the shifted-out readback into the response FIFO (fifo2).
- Runs when the top-level command FSM gives a start pulse, replacing the ad-hoc read-fifo1/write-fifo2 enables of the WRITE state.
- Generates sr_clk, sr_in and sr_load, samples sr_out, and reports done, busy and overflow status to the command FSM and LEDs.

---
 rtl/sr_config_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sr_config_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_config_sequencer.sv
// ---------------------------------------------------------------------------
// sr_config_sequencer
//
// Purpose:
//   Drives the chip's serial configuration shift register. Bytes come from
//   the command FIFO (fifo1) and are shifted out MSB first on sr_in. The
//   readback on sr_out is captured into the response FIFO (fifo2). After the
//   last byte the block pulses sr_load and then reports done.
//
//   Every output is a flop that is decoded from the current FSM state. As a
//   result, each output lags its state by one clk_100 cycle. For example,
//   done appears in the cycle after the DONE state, which is two cycles after
//   a start that finds fifo1 empty.
//
// Optional feature (macro SR_LOOPBACK_EN):
//   This macro adds a loopback input. When loopback=1, readback is taken from
//   the internal sr_in register instead of sr_out, and the external sr_clk
//   and sr_load are held low. fifo2 then receives an exact copy of fifo1.
//
// Parameters:
//   CLK_DIV      sr_clk half-period in clk_100 cycles (1..65535)
//   LOAD_CYCLES  sr_load high time in clk_100 cycles (>= 1)
//
// Ports:
//   loopback     in   1  (SR_LOOPBACK_EN only) self-test loopback select
//   clk_100      in   1  system clock
//   Reset        in   1  synchronous active-high reset, aborts any pass
//   start        in   1  single-cycle pass request, honoured only in IDLE
//   fifo1_dout   in   8  fifo1 read data, valid with rd_ack1
//   fifo1_empty  in   1  fifo1 empty flag
//   rd_ack1      in   1  fifo1 read acknowledge
//   rd_en1       out  1  fifo1 read strobe (one-cycle pulse)
//   fifo2_din    out  8  captured readback byte
//   fifo2_full   in   1  fifo2 full flag
//   wr_en2       out  1  fifo2 write strobe (one-cycle pulse)
//   sr_clk       out  1  shift-register clock to the chip
//   sr_in        out  1  serial data to the chip
//   sr_out       in   1  serial data from the chip (already synchronised)
//   sr_load      out  1  load strobe to the chip
//   busy         out  1  FSM not in IDLE
//   done         out  1  one-cycle pulse at the end of a pass
//   overflow     out  1  sticky: a readback byte was dropped (fifo2 full)
//   bit_count    out 16  bits shifted in current/last pass, saturating
// ---------------------------------------------------------------------------
module sr_config_sequencer #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned LOAD_CYCLES = 100
) (
`ifdef SR_LOOPBACK_EN
    input  logic        loopback,
`endif
    input  logic        clk_100,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  fifo1_dout,
    input  logic        fifo1_empty,
    input  logic        rd_ack1,
    output logic        rd_en1,
    output logic [7:0]  fifo2_din,
    input  logic        fifo2_full,
    output logic        wr_en2,
    output logic        sr_clk,
    output logic        sr_in,
    input  logic        sr_out,
    output logic        sr_load,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] bit_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_ACK, SHIFT, STORE, LOAD, DONE
    } state_e;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [31:0] LOAD_LAST = 32'(LOAD_CYCLES - 1);

    logic lb;
`ifdef SR_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    state_e      state_q, state_d;
    // The bit period of 2*CLK_DIV can exceed 16 bits. It is therefore split
    // into a 16-bit count within one half-period, plus a flag that marks the
    // high half.
    logic [15:0] phase_q, phase_d;
    logic        hi_half_q, hi_half_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [31:0] load_cnt_q, load_cnt_d;

    logic        rd_en1_q, rd_en1_d;
    logic        wr_en2_q, wr_en2_d;
    logic [7:0]  fifo2_din_q, fifo2_din_d;
    logic        sr_clk_q, sr_clk_d;
    logic        sr_in_q, sr_in_d;
    logic        sr_load_q, sr_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic [15:0] bit_count_q, bit_count_d;

    logic        cap_bit;
    assign cap_bit = lb ? sr_in_q : sr_out;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hi_half_d   = hi_half_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        load_cnt_d  = load_cnt_q;
        rd_en1_d    = 1'b0;
        wr_en2_d    = 1'b0;
        fifo2_din_d = fifo2_din_q;
        sr_clk_d    = 1'b0;
        sr_in_d     = sr_in_q;
        sr_load_d   = (state_q == LOAD) && !lb;
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
        overflow_d  = overflow_q;
        bit_count_d = bit_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (fifo1_empty) begin
                        state_d = DONE;
                    end else begin
                        state_d     = FETCH;
                        bit_count_d = '0;
                        overflow_d  = 1'b0;
                    end
                end
            end
            FETCH: begin
                rd_en1_d = 1'b1;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rd_ack1) begin
                    tx_d      = fifo1_dout;
                    bit_idx_d = 3'd7;
                    phase_d   = '0;
                    hi_half_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_clk_d = hi_half_q && !lb;
                if (!hi_half_q) begin
                    if (phase_q == 16'd0) begin
                        sr_in_d = tx_q[bit_idx_q];
                    end
                    if (phase_q == DIV_LAST) begin
                        phase_d   = '0;
                        hi_half_d = 1'b1;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end else begin
                    // The capture happens on the same edge where sr_clk rises.
                    if (phase_q == 16'd0) begin
                        rx_d[bit_idx_q] = cap_bit;
                        if (bit_count_q != 16'hFFFF) begin
                            bit_count_d = bit_count_q + 16'd1;
                        end
                    end
                    if (phase_q == DIV_LAST) begin
                        phase_d   = '0;
                        hi_half_d = 1'b0;
                        if (bit_idx_q == 3'd0) begin
                            state_d = STORE;
                        end else begin
                            bit_idx_d = bit_idx_q - 3'd1;
                        end
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end
            end
            STORE: begin
                if (!fifo2_full) begin
                    wr_en2_d    = 1'b1;
                    fifo2_din_d = rx_q;
                end else begin
                    overflow_d = 1'b1;
                end
                load_cnt_d = '0;
                state_d    = fifo1_empty ? LOAD : FETCH;
            end
            LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = DONE;
                end else begin
                    load_cnt_d = load_cnt_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. This lets
    // every flop sample the pre-edge values of the others.
    always_ff @(posedge clk_100) begin
        if (Reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            hi_half_q   <= 1'b0;
            bit_idx_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            load_cnt_q  <= '0;
            rd_en1_q    <= 1'b0;
            wr_en2_q    <= 1'b0;
            fifo2_din_q <= '0;
            sr_clk_q    <= 1'b0;
            sr_in_q     <= 1'b0;
            sr_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hi_half_q   <= hi_half_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            load_cnt_q  <= load_cnt_d;
            rd_en1_q    <= rd_en1_d;
            wr_en2_q    <= wr_en2_d;
            fifo2_din_q <= fifo2_din_d;
            sr_clk_q    <= sr_clk_d;
            sr_in_q     <= sr_in_d;
            sr_load_q   <= sr_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign rd_en1    = rd_en1_q;
    assign wr_en2    = wr_en2_q;
    assign fifo2_din = fifo2_din_q;
    assign sr_clk    = sr_clk_q;
    assign sr_in     = sr_in_q;
    assign sr_load   = sr_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_sr_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_config_sequencer
//
// Purpose:
//   Exercises sr_config_sequencer with CLK_DIV=2 and LOAD_CYCLES=4.
//
//   fifo1 is modelled as a byte queue that acknowledges each read after a
//   random delay. fifo2 collects every written byte.
//
//   The chip is modelled in one of two ways:
//     - a clk_100 echo register (readback equals the data sent), or
//     - an 8-bit shift register clocked by sr_clk (readback is the previous
//       byte).
//
//   Expected readback, flags and counts are derived per pass from those
//   rules.
// ---------------------------------------------------------------------------
module tb_sr_config_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int LOAD_CYCLES = 4;

    logic        clk_100 = 1'b0;
    logic        Reset, start, fifo1_empty, rd_ack1, fifo2_full, sr_out;
    logic [7:0]  fifo1_dout;
    logic        rd_en1, wr_en2, sr_clk, sr_in, sr_load, busy, done, overflow;
    logic [7:0]  fifo2_din;
    logic [15:0] bit_count;

    sr_config_sequencer #(.CLK_DIV(CLK_DIV), .LOAD_CYCLES(LOAD_CYCLES)) dut (
        .clk_100(clk_100), .Reset(Reset), .start(start),
        .fifo1_dout(fifo1_dout), .fifo1_empty(fifo1_empty), .rd_ack1(rd_ack1),
        .rd_en1(rd_en1), .fifo2_din(fifo2_din), .fifo2_full(fifo2_full),
        .wr_en2(wr_en2), .sr_clk(sr_clk), .sr_in(sr_in), .sr_out(sr_out),
        .sr_load(sr_load), .busy(busy), .done(done), .overflow(overflow),
        .bit_count(bit_count)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Environment and per-pass observations
    logic [7:0] f1_q[$];
    logic [7:0] tx_in[$];
    logic [7:0] got_q[$];
    logic       sent_bits[$];
    logic [7:0] chip8 = 8'h00;
    int         chip_mode;
    int         full_idx;
    int n_rd, n_done, load_cyc, rises, hi_bad, sld_bad, order_bad, done_lat;

    // Reference state carried between passes
    logic [7:0]  chip_ref = 8'h00;
    logic        exp_ovf  = 1'b0;
    logic [15:0] exp_bc   = 16'h0;

    task automatic run_pass(input int reset_at, input int start_at);
        int       ack_wait = -1;
        int       hi_w = 0;
        int       tail = 0;
        logic     prev_sclk = 1'b0;
        logic     prev_in = sr_in;
        logic     load_seen = 1'b0;
        bit       injected = 1'b0;
        bit       rise;
        n_rd = 0; n_done = 0; load_cyc = 0; rises = 0;
        hi_bad = 0; sld_bad = 0; order_bad = 0; done_lat = 0;
        got_q.delete(); sent_bits.delete();
        fifo1_empty = (f1_q.size() == 0);
        sr_out = (chip_mode != 0) ? chip8[7] : sr_in;
        start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(posedge clk_100); #1;
            start = 1'b0;
            if (Reset) begin
                check("rst_outs", 32'({rd_en1, wr_en2, sr_clk, sr_in, sr_load, busy, done, overflow}), 32'h0);
                check("rst_din", 32'(fifo2_din), 32'h0);
                check("rst_bitcnt", 32'(bit_count), 32'h0);
                Reset = 1'b0;
                f1_q.delete();
                fifo1_empty = 1'b1;
                rd_ack1 = 1'b0;
                fifo2_full = 1'b0;
                break;
            end
            // fifo1 responder
            rd_ack1 = 1'b0;
            if (ack_wait == 0) begin
                if (f1_q.size() > 0) begin
                    rd_ack1 = 1'b1;
                    fifo1_dout = f1_q.pop_front();
                end
                fifo1_empty = (f1_q.size() == 0);
                ack_wait = -1;
            end else if (ack_wait > 0) begin
                ack_wait--;
            end
            if (rd_en1) begin
                n_rd++;
                ack_wait = int'($urandom_range(0, 2));
            end
            // fifo2 and load observation
            if (wr_en2) begin
                got_q.push_back(fifo2_din);
                if (load_seen) order_bad++;
            end
            if (sr_load) begin
                load_cyc++;
                load_seen = 1'b1;
                if (sr_clk) sld_bad++;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) done_lat = cyc;
            end
            // sr_clk observation and chip model
            rise = sr_clk && !prev_sclk;
            if (rise) begin
                rises++;
                sent_bits.push_back(sr_in);
                hi_w = 0;
            end
            if (sr_clk) hi_w++;
            if (!sr_clk && prev_sclk && hi_w != CLK_DIV) hi_bad++;
            prev_sclk = sr_clk;
            if (chip_mode == 0) begin
                sr_out = prev_in;
            end else if (rise) begin
                chip8 = {chip8[6:0], sr_in};
                sr_out = chip8[7];
            end
            prev_in = sr_in;
            fifo2_full = (full_idx >= 0) && (rises == 8 * (full_idx + 1));
            if (start_at >= 0 && !injected && rises >= start_at) begin
                start = 1'b1;
                injected = 1'b1;
            end
            if (reset_at >= 0 && rises == reset_at) Reset = 1'b1;
            if (n_done > 0) tail++;
            if (tail > 4) break;
        end
        start = 1'b0;
        fifo2_full = 1'b0;
        rd_ack1 = 1'b0;
    endtask

    task automatic do_pass(input int mode, input int fidx, input int start_at);
        logic [7:0] exp_wr[$];
        logic [7:0] v;
        logic [7:0] packed_b;
        int n = tx_in.size();
        chip_mode = mode;
        full_idx  = fidx;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) v = tx_in[i];
            else v = (i == 0) ? chip_ref : tx_in[i - 1];
            if (i != fidx) exp_wr.push_back(v);
        end
        if (n > 0) begin
            if (mode != 0) chip_ref = tx_in[n - 1];
            exp_ovf = (fidx >= 0);
            exp_bc  = 16'(8 * n);
        end
        f1_q = tx_in;
        run_pass(-1, start_at);
        check("done_cnt", 32'(n_done), 32'd1);
        if (n == 0) check("empty_done_lat", 32'(done_lat), 32'd2);
        check("rd_en1_cnt", 32'(n_rd), 32'(n));
        check("wr_en2_cnt", 32'(got_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < got_q.size() && i < exp_wr.size(); i++)
            check("fifo2_data", 32'(got_q[i]), 32'(exp_wr[i]));
        check("bit_count", 32'(bit_count), 32'(exp_bc));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("sr_load_len", 32'(load_cyc), (n > 0) ? 32'(LOAD_CYCLES) : 32'd0);
        check("sr_clk_rises", 32'(rises), 32'(8 * n));
        if (sent_bits.size() >= 8 * n) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 0; b < 8; b++) packed_b[7 - b] = sent_bits[8 * i + b];
                check("sr_in_byte", 32'(packed_b), 32'(tx_in[i]));
            end
        end
        check("sr_clk_high_width", 32'(hi_bad), 32'd0);
        check("sr_clk_during_load", 32'(sld_bad), 32'd0);
        check("write_before_load", 32'(order_bad), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int fidx;
        Reset = 1'b1; start = 1'b0; fifo1_dout = 8'h00; fifo1_empty = 1'b1;
        rd_ack1 = 1'b0; fifo2_full = 1'b0; sr_out = 1'b0;
        chip_mode = 0; full_idx = -1;
        repeat (3) @(posedge clk_100);
        #1;
        check("reset_outs", 32'({rd_en1, wr_en2, sr_clk, sr_in, sr_load, busy, done, overflow}), 32'h0);
        check("reset_bitcnt", 32'(bit_count), 32'h0);
        Reset = 1'b0;
        @(posedge clk_100); #1;

        // Start with fifo1 empty
        tx_in = {};
        do_pass(0, -1, -1);

        // Single byte through the echo register
        tx_in = {8'hA5};
        do_pass(0, -1, -1);

        // Chip returns its input delayed by one byte
        tx_in = {8'h01, 8'hFF, 8'h80};
        do_pass(1, -1, -1);

        // fifo2 full during the second store
        tx_in = {8'h5A, 8'hC3};
        do_pass(0, 1, -1);

        // Overflow stays set across a start that finds fifo1 empty
        tx_in = {};
        do_pass(0, -1, -1);

        // Reset during bit 3, then a clean pass
        chip_mode = 0; full_idx = -1;
        f1_q = {8'h96, 8'h3C};
        run_pass(5, -1);
        exp_ovf = 1'b0;
        exp_bc  = 16'h0;
        @(posedge clk_100); #1;
        check("post_reset_busy", 32'(busy), 32'd0);
        tx_in = {8'h69};
        do_pass(0, -1, -1);

        // start pulsed during SHIFT is ignored
        tx_in = {8'h3C, 8'h96};
        do_pass(0, -1, 3);

        // Randomized passes
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 4));
            tx_in = {};
            for (int i = 0; i < n; i++) tx_in.push_back(8'($urandom));
            fidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            do_pass(int'($urandom_range(0, 1)), fidx, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
